pid_axis_sched: RTL and testbench

Scheduler that time-shares one PID compute engine between the X and Y tip/tilt axes of the adaptive-optics loop. It accepts error samples from both axes over a req/ack handshake and arbitrates round-robin. It issues each sample to the engine with an axis select for the gain bank, and writes the saturated result into per-axis control registers that feed the DAC path. A watchdog aborts any engine operation that fails to complete.

---
 rtl/pid_axis_sched.sv | 128 ++++++++++++
 tb/tb_pid_axis_sched.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_axis_sched.sv
// Round-robin scheduler sharing one PID engine between the X and Y tip/tilt axes.
// Issues samples, clamps returned results into per-axis control registers, and aborts hung operations.
module pid_axis_sched #(
   parameter int                       DATA_W    = 16,
   parameter int                       TIMEOUT   = 64,
   parameter logic signed [DATA_W-1:0] SAT_LIMIT = 16'sd16384
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     req_x,
   input  logic signed [DATA_W-1:0] err_x,
   output logic                     ack_x,
   input  logic                     req_y,
   input  logic signed [DATA_W-1:0] err_y,
   output logic                     ack_y,
   output logic                     pid_start,
   output logic                     pid_sel,
   output logic signed [DATA_W-1:0] pid_err,
   input  logic                     pid_done,
   input  logic signed [DATA_W-1:0] pid_result,
   output logic signed [DATA_W-1:0] ctrl_x,
   output logic signed [DATA_W-1:0] ctrl_y,
   output logic                     upd_x,
   output logic                     upd_y,
   output logic                     busy,
   output logic                     fault,
   input  logic                     clr_fault
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

   localparam int                       WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0]          WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic signed [DATA_W-1:0] SAT_NEG = -SAT_LIMIT;

   state_t                     state;
   logic                       last_y;
   logic [WD_W-1:0]            wd;
   logic                       grant_y;
   logic signed [DATA_W-1:0]   clamped;

   // Y wins when it is the only requester, or on a tie when X was served last.
   always_comb begin
      grant_y = req_y && (!req_x || !last_y);
      if (pid_result > SAT_LIMIT)
         clamped = SAT_LIMIT;
      else if (pid_result < SAT_NEG)
         clamped = SAT_NEG;
      else
         clamped = pid_result;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         last_y    <= 1'b1;
         wd        <= '0;
         pid_sel   <= 1'b0;
         pid_err   <= '0;
         pid_start <= 1'b0;
         ack_x     <= 1'b0;
         ack_y     <= 1'b0;
         ctrl_x    <= '0;
         ctrl_y    <= '0;
         upd_x     <= 1'b0;
         upd_y     <= 1'b0;
         busy      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low every cycle, so any branch that raises one yields exactly one cycle.
         pid_start <= 1'b0;
         ack_x     <= 1'b0;
         ack_y     <= 1'b0;
         upd_x     <= 1'b0;
         upd_y     <= 1'b0;
         if (clr_fault)
            fault <= 1'b0;

         case (state)
            IDLE: begin
               if (enable && (req_x || req_y)) begin
                  pid_sel   <= grant_y;
                  pid_err   <= grant_y ? err_y : err_x;
                  pid_start <= 1'b1;
                  ack_x     <= !grant_y;
                  ack_y     <= grant_y;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               last_y <= pid_sel;
               wd     <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (pid_done) begin
                  if (pid_sel) begin
                     ctrl_y <= clamped;
                     upd_y  <= 1'b1;
                  end else begin
                     ctrl_x <= clamped;
                     upd_x  <= 1'b1;
                  end
                  state <= WRITE;
               end else if (wd == WD_LAST) begin
                  // Later assignment overrides a same-cycle clr_fault.
                  fault <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            WRITE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pid_axis_sched.sv
// Self-checking bench for pid_axis_sched: directed scenarios plus randomized traffic
// compared against a behavioural arbitration and clamp model.
module tb_pid_axis_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        req_x = 1'b0, req_y = 1'b0;
   logic [15:0] err_x = '0, err_y = '0;
   logic        ack_x, ack_y;
   logic        pid_start, pid_sel;
   logic [15:0] pid_err;
   logic        pid_done = 1'b0;
   logic [15:0] pid_result = '0;
   logic [15:0] ctrl_x, ctrl_y;
   logic        upd_x, upd_y, busy, fault;
   logic        clr_fault = 1'b0;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [15:0] exp_x, exp_y;

   // Pulse monitor
   int n_ack_x = 0, n_ack_y = 0, n_upd_x = 0, n_upd_y = 0, n_both = 0;
   int grant_q[$];

   pid_axis_sched dut (
      .clk(clk), .rst(rst), .enable(enable),
      .req_x(req_x), .err_x(err_x), .ack_x(ack_x),
      .req_y(req_y), .err_y(err_y), .ack_y(ack_y),
      .pid_start(pid_start), .pid_sel(pid_sel), .pid_err(pid_err),
      .pid_done(pid_done), .pid_result(pid_result),
      .ctrl_x(ctrl_x), .ctrl_y(ctrl_y), .upd_x(upd_x), .upd_y(upd_y),
      .busy(busy), .fault(fault), .clr_fault(clr_fault)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ack_x === 1'b1) begin n_ack_x++; grant_q.push_back(0); end
      if (ack_y === 1'b1) begin n_ack_y++; grant_q.push_back(1); end
      if (ack_x === 1'b1 && ack_y === 1'b1) n_both++;
      if (upd_x === 1'b1) n_upd_x++;
      if (upd_y === 1'b1) n_upd_y++;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   function automatic logic [15:0] clamp_ref(input logic [15:0] r);
      int v;
      v = $signed(r);
      if (v > 16384) v = 16384;
      else if (v < -16384) v = -16384;
      return 16'(v);
   endfunction

   task automatic do_reset();
      rst = 1'b1; enable = 1'b1; req_x = 0; req_y = 0; pid_done = 0; clr_fault = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_x = '0; exp_y = '0;
      @(negedge clk);
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (pid_start === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL start_wait: pid_start never rose, required 1 within 10 cycles");
      end
   endtask

   // Engine stub: result presented lat cycles after the ISSUE cycle; returns at the WRITE-cycle negedge.
   task automatic engine_reply(input int lat, input logic [15:0] res);
      repeat (lat) @(negedge clk);
      pid_done = 1'b1; pid_result = res;
      @(negedge clk);
      pid_done = 1'b0; pid_result = 16'($urandom);
   endtask

   task automatic test_reset();
      bit ok;
      int ux, uy;
      rst = 1'b1; enable = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({ctrl_x, ctrl_y, pid_err} !== 48'h0 || {busy, fault, pid_start, ack_x, ack_y, upd_x, upd_y, pid_sel} !== 8'h0) begin
         failures++;
         $display("FAIL reset_values: ctrl_x=%h ctrl_y=%h pid_err=%h flags=%b required all zero",
                  ctrl_x, ctrl_y, pid_err, {busy, fault, pid_start, ack_x, ack_y, upd_x, upd_y, pid_sel});
      end
      rst = 1'b0;
      exp_x = '0; exp_y = '0;
      @(negedge clk);
      // Load a nonzero ctrl_x so the later reset has something to clear.
      err_x = 16'h0010; req_x = 1'b1;
      wait_start(ok); req_x = 1'b0;
      engine_reply(1, 16'h0300);
      checks++;
      if (ctrl_x !== 16'h0300) begin
         failures++; $display("FAIL reset_preload: ctrl_x=%h required 0300", ctrl_x);
      end
      err_x = 16'h1234; req_x = 1'b1;
      wait_start(ok); req_x = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL reset_in_wait: busy=%b required 1", busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || ctrl_x !== 16'h0 || ctrl_y !== 16'h0 || fault !== 1'b0 || pid_err !== 16'h0) begin
         failures++;
         $display("FAIL reset_async: busy=%b ctrl_x=%h ctrl_y=%h fault=%b pid_err=%h required 0",
                  busy, ctrl_x, ctrl_y, fault, pid_err);
      end
      @(negedge clk);
      rst = 1'b0;
      ux = n_upd_x; uy = n_upd_y;
      pid_done = 1'b1; pid_result = 16'h0200;
      @(negedge clk);
      pid_done = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (n_upd_x != ux || n_upd_y != uy || ctrl_x !== 16'h0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_discard: upd_x_pulses=%0d upd_y_pulses=%0d ctrl_x=%h busy=%b required 0 0 0000 0",
                  n_upd_x - ux, n_upd_y - uy, ctrl_x, busy);
      end
   endtask

   task automatic test_single_x();
      bit ok;
      int ax, ay, ux, uy;
      ax = n_ack_x; ay = n_ack_y; ux = n_upd_x; uy = n_upd_y;
      err_x = 16'h0100; req_x = 1'b1;
      wait_start(ok);
      checks++;
      if (ack_x !== 1'b1 || ack_y !== 1'b0 || pid_sel !== 1'b0 || pid_err !== 16'h0100) begin
         failures++;
         $display("FAIL single_issue: ack_x=%b ack_y=%b pid_sel=%b pid_err=%h required 1 0 0 0100",
                  ack_x, ack_y, pid_sel, pid_err);
      end
      req_x = 1'b0;
      engine_reply(3, 16'h0800);
      exp_x = 16'h0800;
      checks++;
      if (ctrl_x !== exp_x || upd_x !== 1'b1 || upd_y !== 1'b0 || ctrl_y !== exp_y) begin
         failures++;
         $display("FAIL single_write: ctrl_x=%h upd_x=%b upd_y=%b ctrl_y=%h required %h 1 0 %h",
                  ctrl_x, upd_x, upd_y, ctrl_y, exp_x, exp_y);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (n_ack_x - ax != 1 || n_ack_y != ay || n_upd_x - ux != 1 || n_upd_y != uy || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_pulses: ack_x=%0d ack_y=%0d upd_x=%0d upd_y=%0d busy=%b required 1 0 1 0 0",
                  n_ack_x - ax, n_ack_y - ay, n_upd_x - ux, n_upd_y - uy, busy);
      end
   endtask

   task automatic test_round_robin();
      bit ok, last, gy;
      int both0;
      int exp_order[4];
      logic [15:0] res;
      exp_order = '{0, 1, 0, 1};
      do_reset();
      last = 1'b1;
      err_x = 16'($urandom); err_y = 16'($urandom);
      req_x = 1'b1; req_y = 1'b1;
      grant_q.delete();
      both0 = n_both;
      for (int k = 0; k < 4; k++) begin
         wait_start(ok);
         if (!ok) break;
         gy = !last;
         last = gy;
         checks++;
         if (pid_sel !== gy || pid_err !== (gy ? err_y : err_x)) begin
            failures++;
            $display("FAIL rr_issue%0d: pid_sel=%b pid_err=%h required %b %h", k, pid_sel, pid_err, gy, gy ? err_y : err_x);
         end
         if (k == 3) begin req_x = 1'b0; req_y = 1'b0; end
         res = 16'($urandom);
         engine_reply(1, res);
         if (gy) exp_y = clamp_ref(res); else exp_x = clamp_ref(res);
         checks++;
         if (ctrl_x !== exp_x || ctrl_y !== exp_y) begin
            failures++;
            $display("FAIL rr_ctrl%0d: ctrl_x=%h ctrl_y=%h required %h %h", k, ctrl_x, ctrl_y, exp_x, exp_y);
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (grant_q.size() != 4) begin
         failures++; $display("FAIL rr_count: grants=%0d required 4", grant_q.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (grant_q[k] != exp_order[k]) begin
               failures++; $display("FAIL rr_order%0d: axis=%0d required %0d", k, grant_q[k], exp_order[k]);
            end
         end
      end
      checks++;
      if (n_both != both0) begin
         failures++; $display("FAIL rr_double_ack: both_acks=%0d required 0", n_both - both0);
      end
   endtask

   task automatic test_saturation();
      bit ok;
      logic [15:0] vals [6];
      vals = '{16'h7000, 16'h9000, 16'h4000, 16'hC000, 16'hBFFF, 16'h4001};
      for (int k = 0; k < 6; k++) begin
         err_x = 16'($urandom); req_x = 1'b1;
         wait_start(ok); req_x = 1'b0;
         if (!ok) break;
         engine_reply(1 + $urandom_range(0, 2), vals[k]);
         exp_x = clamp_ref(vals[k]);
         checks++;
         if (ctrl_x !== exp_x || upd_x !== 1'b1) begin
            failures++;
            $display("FAIL sat_%h: ctrl_x=%h upd_x=%b required %h 1", vals[k], ctrl_x, upd_x, exp_x);
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int ux, uy;
      logic [15:0] res;
      do_reset();
      err_y = 16'($urandom); req_y = 1'b1;
      wait_start(ok); req_y = 1'b0;
      ux = n_upd_x; uy = n_upd_y;
      repeat (64) @(negedge clk);
      checks++;
      if (fault !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL to_early: fault=%b busy=%b after 63 wait cycles required 0 1", fault, busy);
      end
      @(negedge clk);
      checks++;
      if (fault !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL to_expire: fault=%b busy=%b required 1 0", fault, busy);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (n_upd_x != ux || n_upd_y != uy || ctrl_x !== exp_x || ctrl_y !== exp_y) begin
         failures++;
         $display("FAIL to_no_write: upd pulses=%0d ctrl_x=%h ctrl_y=%h required 0 %h %h",
                  (n_upd_x - ux) + (n_upd_y - uy), ctrl_x, ctrl_y, exp_x, exp_y);
      end
      // Fault does not block service.
      err_x = 16'($urandom); req_x = 1'b1;
      wait_start(ok); req_x = 1'b0;
      res = 16'($urandom);
      engine_reply(2, res);
      exp_x = clamp_ref(res);
      checks++;
      if (upd_x !== 1'b1 || ctrl_x !== exp_x || fault !== 1'b1) begin
         failures++;
         $display("FAIL to_recover: upd_x=%b ctrl_x=%h fault=%b required 1 %h 1", upd_x, ctrl_x, fault, exp_x);
      end
      clr_fault = 1'b1;
      @(negedge clk);
      clr_fault = 1'b0;
      checks++;
      if (fault !== 1'b0) begin
         failures++; $display("FAIL to_clear: fault=%b required 0", fault);
      end
      // Done on the expiry cycle wins.
      err_x = 16'($urandom); req_x = 1'b1;
      wait_start(ok); req_x = 1'b0;
      res = 16'($urandom);
      engine_reply(64, res);
      exp_x = clamp_ref(res);
      checks++;
      if (upd_x !== 1'b1 || ctrl_x !== exp_x || fault !== 1'b0) begin
         failures++;
         $display("FAIL to_coincident: upd_x=%b ctrl_x=%h fault=%b required 1 %h 0", upd_x, ctrl_x, fault, exp_x);
      end
      // Set beats a same-cycle clear.
      err_y = 16'($urandom); req_y = 1'b1;
      wait_start(ok); req_y = 1'b0;
      repeat (64) @(negedge clk);
      clr_fault = 1'b1;
      @(negedge clk);
      clr_fault = 1'b0;
      checks++;
      if (fault !== 1'b1) begin
         failures++; $display("FAIL to_set_wins: fault=%b required 1", fault);
      end
      clr_fault = 1'b1;
      @(negedge clk);
      clr_fault = 1'b0;
      checks++;
      if (fault !== 1'b0) begin
         failures++; $display("FAIL to_clear2: fault=%b required 0", fault);
      end
   endtask

   task automatic test_enable();
      bit ok;
      int ay;
      logic [15:0] res;
      enable = 1'b0;
      err_y = 16'($urandom); req_y = 1'b1;
      ay = n_ack_y;
      repeat (5) @(negedge clk);
      checks++;
      if (n_ack_y != ay || busy !== 1'b0) begin
         failures++; $display("FAIL en_gated: ack_y pulses=%0d busy=%b required 0 0", n_ack_y - ay, busy);
      end
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 2 && !ok; i++) begin
         @(negedge clk);
         if (ack_y === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!ok || pid_err !== err_y) begin
         failures++; $display("FAIL en_release: ack_y_seen=%b pid_err=%h required 1 %h", ok, pid_err, err_y);
      end
      req_y = 1'b0;
      enable = 1'b0;
      res = 16'($urandom);
      engine_reply(3, res);
      exp_y = clamp_ref(res);
      checks++;
      if (upd_y !== 1'b1 || ctrl_y !== exp_y) begin
         failures++; $display("FAIL en_inflight: upd_y=%b ctrl_y=%h required 1 %h", upd_y, ctrl_y, exp_y);
      end
      enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random();
      bit ok, px, py, gy, last;
      logic [15:0] ex, ey, res, exp;
      do_reset();
      last = 1'b1;
      px = 1'b0; py = 1'b0; ex = '0; ey = '0;
      for (int n = 0; n < 30; n++) begin
         if (!px && $urandom_range(0, 1) == 1) begin px = 1'b1; ex = 16'($urandom); end
         if (!py && $urandom_range(0, 1) == 1) begin py = 1'b1; ey = 16'($urandom); end
         if (!px && !py) begin px = 1'b1; ex = 16'($urandom); end
         req_x = px; err_x = ex; req_y = py; err_y = ey;
         if (px && py) gy = !last;
         else gy = py;
         wait_start(ok);
         if (!ok) break;
         checks++;
         if (ack_x !== !gy || ack_y !== gy || pid_sel !== gy || pid_err !== (gy ? ey : ex)) begin
            failures++;
            $display("FAIL rand_issue%0d: ack_x=%b ack_y=%b pid_sel=%b pid_err=%h required %b %b %b %h",
                     n, ack_x, ack_y, pid_sel, pid_err, !gy, gy, gy, gy ? ey : ex);
         end
         last = gy;
         if (gy) py = 1'b0; else px = 1'b0;
         if (n == 29) begin px = 1'b0; py = 1'b0; end
         req_x = px; req_y = py;
         res = 16'($urandom);
         engine_reply($urandom_range(1, 6), res);
         exp = clamp_ref(res);
         if (gy) exp_y = exp; else exp_x = exp;
         checks++;
         if (upd_x !== !gy || upd_y !== gy || ctrl_x !== exp_x || ctrl_y !== exp_y) begin
            failures++;
            $display("FAIL rand_write%0d: upd_x=%b upd_y=%b ctrl_x=%h ctrl_y=%h required %b %b %h %h",
                     n, upd_x, upd_y, ctrl_x, ctrl_y, !gy, gy, exp_x, exp_y);
         end
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_x();
      test_round_robin();
      test_saturation();
      test_timeout();
      test_enable();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
